dht11_reader: RTL and testbench

DHT11_READER -- requirements
Module: dht11_reader

---
 rtl/dht11_reader.sv | 202 ++++++++++++++++++++
 tb/tb_dht11_reader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire sensor reader.
// Sends the host start pulse, follows the sensor's response handshake,
// decodes 40 data bits by their high-phase width and validates the checksum.
// A good frame is presented as {humidity_int, temperature_int} with a
// ready/data_used handshake; a failed read raises error until the next start.
module dht11_reader #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int START_US      = 18000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        dht_in,
   output logic        dht_oe,
   output logic [15:0] data_out,
   output logic        ready,
   input  logic        data_used,
   output logic        busy,
   output logic        error
);

   localparam int TICKS_PER_US = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int PW           = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam int T_A          = (START_US > TIMEOUT_US) ? START_US : TIMEOUT_US;
   localparam int T_MAX        = ((T_A > BIT_THRESH_US) ? T_A : BIT_THRESH_US) + 1;
   localparam int TW           = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      WAIT_ACK,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   state_t          state;
   state_t          state_next;

   logic            sync1;
   logic            sync2;
   logic            sync_prev;
   logic            rise;
   logic            fall;

   logic [PW-1:0]   presc;
   logic            tick;
   logic [TW-1:0]   timer;
   logic            phase_done;

   logic [5:0]      bit_cnt;
   logic [39:0]     shift;
   logic            shift_bit;
   logic [7:0]      sum;

   logic            accept;
   logic            shift_en;
   logic            frame_ok;
   logic            frame_bad;
   logic            timeout;

   // Edges are seen on the synchronized line one cycle after it settles.
   assign rise       = sync2 & ~sync_prev;
   assign fall       = ~sync2 & sync_prev;
   assign tick       = (presc == PW'(TICKS_PER_US - 1));
   assign phase_done = tick && (timer == TW'(TIMEOUT_US - 1));
   assign shift_bit  = (timer > TW'(BIT_THRESH_US));
   assign sum        = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of block ordering.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      accept     = 1'b0;
      shift_en   = 1'b0;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      timeout    = 1'b0;
      dht_oe     = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept     = 1'b1;
               state_next = START_LOW;
            end
         end
         START_LOW: begin
            dht_oe = 1'b1;
            if (tick && timer == TW'(START_US - 1)) begin
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (fall)            state_next = RESP_LOW;
            else if (phase_done) timeout    = 1'b1;
         end
         RESP_LOW: begin
            if (rise)            state_next = RESP_HIGH;
            else if (phase_done) timeout    = 1'b1;
         end
         RESP_HIGH: begin
            if (fall)            state_next = BIT_LOW;
            else if (phase_done) timeout    = 1'b1;
         end
         BIT_LOW: begin
            if (rise)            state_next = BIT_HIGH;
            else if (phase_done) timeout    = 1'b1;
         end
         BIT_HIGH: begin
            if (fall) begin
               shift_en   = 1'b1;
               state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
            end else if (phase_done) begin
               timeout = 1'b1;
            end
         end
         CHECK: begin
            if (shift[7:0] == sum) frame_ok  = 1'b1;
            else                   frame_bad = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (timeout) state_next = IDLE;
   end

   // Two-flop synchronizer plus the previous sample for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync1     <= dht_in;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   // Microsecond prescaler and phase timer, both restarted on every state change.
   always_ff @(posedge clk) begin
      if (reset || (state_next != state)) begin
         presc <= '0;
         timer <= '0;
      end else begin
         if (tick) presc <= '0;
         else      presc <= presc + 1'b1;
         if (tick && timer != TW'(T_MAX)) timer <= timer + 1'b1;
      end
   end

   // Data bit shift register, MSB first, with received-bit count.
   always_ff @(posedge clk) begin
      if (reset || accept) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         shift   <= {shift[38:0], shift_bit};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Result registers: frame data, ready handshake and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= 16'h0000;
         ready    <= 1'b0;
         error    <= 1'b0;
      end else if (accept) begin
         ready <= 1'b0;
         error <= 1'b0;
      end else begin
         // NOTE: the later assignment to ready wins, so a new valid frame
         // overrides a simultaneous consumer acknowledge.
         if (data_used) ready <= 1'b0;
         if (frame_ok) begin
            ready    <= 1'b1;
            data_out <= {shift[39:32], shift[23:16]};
         end
         if (frame_bad || timeout) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench for dht11_reader at 1 MHz (one tick per cycle).
// A sensor model drives the line; an event-queue model predicts the outputs
// cycle by cycle from the protocol rules and one process compares them.
module tb_dht11_reader;

   localparam int START_US   = 100;
   localparam int TIMEOUT_US = 200;
   localparam int SYNC_LAT   = 4;   // line change -> outputs: 2 sync flops + decode + check

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        data_used = 1'b0;
   logic        sensor = 1'b1;
   logic        dht_in;
   logic        dht_oe;
   logic [15:0] data_out;
   logic        ready;
   logic        busy;
   logic        error;

   dht11_reader #(
      .CLK_HZ       (1_000_000),
      .START_US     (START_US),
      .TIMEOUT_US   (TIMEOUT_US),
      .BIT_THRESH_US(50)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dht_in   (dht_in),
      .dht_oe   (dht_oe),
      .data_out (data_out),
      .ready    (ready),
      .data_used(data_used),
      .busy     (busy),
      .error    (error)
   );

   // Open-drain line: host pulls low when dht_oe, otherwise sensor level.
   assign dht_in = dht_oe ? 1'b0 : sensor;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef enum int {EV_BUSY, EV_READY, EV_ERROR, EV_DATA, EV_OE} ev_kind_t;
   typedef struct {
      int          at;
      ev_kind_t    kind;
      logic [15:0] val;
   } ev_t;

   ev_t         evq[$];
   logic        exp_busy  = 1'b0;
   logic        exp_ready = 1'b0;
   logic        exp_error = 1'b0;
   logic        exp_oe    = 1'b0;
   logic [15:0] exp_data  = 16'h0000;
   bit          chk_en    = 1'b0;
   int          t_wait    = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   function automatic void push(input int at, input ev_kind_t kind, input logic [15:0] val);
      ev_t e;
      e.at   = at;
      e.kind = kind;
      e.val  = val;
      evq.push_back(e);
   endfunction

   function automatic void apply_events();
      int i = 0;
      while (i < evq.size()) begin
         if (evq[i].at <= cyc) begin
            case (evq[i].kind)
               EV_BUSY:  exp_busy  = evq[i].val[0];
               EV_READY: exp_ready = evq[i].val[0];
               EV_ERROR: exp_error = evq[i].val[0];
               EV_DATA:  exp_data  = evq[i].val;
               EV_OE:    exp_oe    = evq[i].val[0];
               default:  ;
            endcase
            evq.delete(i);
         end else begin
            i++;
         end
      end
   endfunction

   // Model update just after each edge, comparison mid-cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         apply_events();
         #3;
         if (chk_en) begin
            check("busy",     busy,     exp_busy);
            check("ready",    ready,    exp_ready);
            check("error",    error,    exp_error);
            check("data_out", data_out, exp_data);
            check("dht_oe",   dht_oe,   exp_oe);
         end
      end
   end

   // Stimulus changes 2 time units after an edge; it is sampled on the next edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Start is honoured only while no read is in progress.
   function automatic bit model_start();
      if (exp_busy) return 1'b0;
      push(cyc + 1, EV_BUSY,  16'd1);
      push(cyc + 1, EV_READY, 16'd0);
      push(cyc + 1, EV_ERROR, 16'd0);
      push(cyc + 1, EV_OE,    16'd1);
      push(cyc + 1 + START_US, EV_OE, 16'd0);
      t_wait = cyc + 1 + START_US;
      return 1'b1;
   endfunction

   task automatic pulse_start(output bit acc);
      start = 1'b1;
      acc   = model_start();
      step();
      start = 1'b0;
   endtask

   task automatic pulse_du();
      data_used = 1'b1;
      if (exp_ready) push(cyc + 1, EV_READY, 16'd0);
      step();
      data_used = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      evq.delete();
      push(cyc + 1, EV_BUSY,  16'd0);
      push(cyc + 1, EV_READY, 16'd0);
      push(cyc + 1, EV_ERROR, 16'd0);
      push(cyc + 1, EV_DATA,  16'd0);
      push(cyc + 1, EV_OE,    16'd0);
      step();
      reset = 1'b0;
   endtask

   // Wait n cycles; with noise, occasionally fire a start that must be ignored.
   task automatic hold(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         if (noise && ($urandom % 25 == 0)) begin
            start = 1'b1;
            void'(model_start());
         end
         step();
         start = 1'b0;
      end
   endtask

   function automatic logic [39:0] mk_frame(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input bit good);
      logic [7:0] cs;
      cs = b0 + b1 + b2 + b3;
      if (!good) cs = cs + 8'd1;
      return {b0, b1, b2, b3, cs};
   endfunction

   // Sensor side of one read. abort_bit >= 0 resets the DUT during that bit.
   task automatic send_frame(input logic [39:0] frame, input int abort_bit, input bit du_collide);
      int         target;
      int         d;
      logic [7:0] s;
      target = t_wait + int'($urandom_range(20, 40));
      while (cyc < target) step();
      sensor = 1'b0;
      hold(80, 1'b1);
      sensor = 1'b1;
      hold(80, 1'b1);
      for (int i = 0; i < 40; i++) begin
         bit b = frame[39 - i];
         sensor = 1'b0;
         hold(int'($urandom_range(45, 55)), 1'b1);
         sensor = 1'b1;
         if (i == abort_bit) begin
            hold(10, 1'b0);
            pulse_reset();
            return;
         end
         hold(b ? int'($urandom_range(60, 80)) : int'($urandom_range(18, 38)), 1'b1);
      end
      sensor = 1'b0;
      d = cyc;
      s = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      if (s == frame[7:0]) begin
         push(d + SYNC_LAT, EV_READY, 16'd1);
         push(d + SYNC_LAT, EV_DATA,  {frame[39:32], frame[23:16]});
      end else begin
         push(d + SYNC_LAT, EV_ERROR, 16'd1);
      end
      push(d + SYNC_LAT, EV_BUSY, 16'd0);
      if (du_collide) begin
         hold(SYNC_LAT - 1, 1'b0);
         pulse_du();
         hold(50 - SYNC_LAT, 1'b0);
      end else begin
         hold(50, 1'b0);
      end
      sensor = 1'b1;
      hold(5, 1'b0);
   endtask

   // Directed read; optionally measures the start-pulse length off the pad.
   task automatic read_frame(input logic [39:0] frame, input int abort_bit, input bit du_collide,
                             input bit measure);
      bit acc;
      int n;
      pulse_start(acc);
      check("start_accepted", {31'd0, acc}, 32'd1);
      if (measure) begin
         n = 0;
         while (dht_oe && n < 300) begin
            step();
            n++;
         end
         check("start_low_len", n, 32'd100);
      end
      send_frame(frame, abort_bit, du_collide);
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          n;
      logic [39:0] f;

      // Reset state.
      reset = 1'b1;
      step();
      step();
      chk_en = 1'b1;
      reset  = 1'b0;
      check("rst_data",  data_out, 32'h0);
      check("rst_ready", ready,    32'd0);
      check("rst_busy",  busy,     32'd0);
      check("rst_oe",    dht_oe,   32'd0);
      hold(10, 1'b0);

      // Known-good frame: 0x37,0x00,0x19,0x00,0x50.
      read_frame(40'h37_00_19_00_50, -1, 1'b0, 1'b1);
      check("f1_data",  data_out, 32'h3719);
      check("f1_ready", ready,    32'd1);
      check("f1_error", error,    32'd0);

      // Consumer acknowledge clears ready, data holds.
      pulse_du();
      check("du_ready", ready,    32'd0);
      check("du_data",  data_out, 32'h3719);
      hold(5, 1'b0);
      pulse_du();
      hold(5, 1'b0);

      // Bad checksum keeps the previous data.
      read_frame(40'h37_00_19_00_51, -1, 1'b0, 1'b0);
      check("f2_error", error,    32'd1);
      check("f2_ready", ready,    32'd0);
      check("f2_data",  data_out, 32'h3719);
      hold(10, 1'b0);

      // Silent sensor: timeout TIMEOUT_US ticks after the line is released.
      pulse_start(acc);
      check("to_accepted", {31'd0, acc}, 32'd1);
      push(t_wait + TIMEOUT_US, EV_ERROR, 16'd1);
      push(t_wait + TIMEOUT_US, EV_BUSY,  16'd0);
      n = 0;
      while (dht_oe && n < 300) begin
         step();
         n++;
      end
      n = 0;
      while (!error && n < 400) begin
         step();
         n++;
      end
      check("to_len",  n,    32'd200);
      check("to_busy", busy, 32'd0);
      hold(10, 1'b0);

      // Randomised frames, some with bad checksums or a colliding acknowledge.
      for (int k = 0; k < 6; k++) begin
         f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      ($urandom % 4) != 0);
         read_frame(f, -1, ($urandom % 2) == 1, 1'b0);
         hold(int'($urandom_range(2, 20)), 1'b0);
         if ($urandom % 2 == 1) pulse_du();
         hold(int'($urandom_range(2, 20)), 1'b0);
      end

      // Reset in the middle of bit 20, then a full read succeeds.
      read_frame(mk_frame(8'h55, 8'h01, 8'h22, 8'h02, 1'b1), 20, 1'b0, 1'b0);
      check("mid_rst_data",  data_out, 32'h0);
      check("mid_rst_busy",  busy,     32'd0);
      check("mid_rst_ready", ready,    32'd0);
      check("mid_rst_oe",    dht_oe,   32'd0);
      hold(20, 1'b0);
      read_frame(40'h37_00_19_00_50, -1, 1'b1, 1'b0);
      check("f3_data",  data_out, 32'h3719);
      check("f3_ready", ready,    32'd1);
      check("f3_error", error,    32'd0);
      hold(5, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
